// File: rtl/tilemap_port_arbiter_if.sv
// Tilemap port bundle: renderer (r_*) and collision (c_*) read clients plus the RAM side.
// The arbiter takes the slave view; clients and the RAM model take the master view.
interface tilemap_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 4
);
  logic              r_req;
  logic              r_lock;
  logic [ADDR_W-1:0] r_addr;
  logic              r_gnt;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  logic              c_req;
  logic              c_lock;
  logic [ADDR_W-1:0] c_addr;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              busy;

  modport slave (
    input  r_req, r_lock, r_addr, c_req, c_lock, c_addr, mem_data,
    output r_gnt, r_rvalid, r_rdata, c_gnt, c_rvalid, c_rdata, mem_address, busy
  );

  modport master (
    output r_req, r_lock, r_addr, c_req, c_lock, c_addr, mem_data,
    input  r_gnt, r_rvalid, r_rdata, c_gnt, c_rvalid, c_rdata, mem_address, busy
  );
endinterface

// File: rtl/tilemap_port_arbiter.sv
// Round-robin arbiter for the single-port tilemap RAM with bounded lock ownership
// and a tagged read-return pipeline.
//
// state | meaning
// IDLE  | no owner; round-robin between requesters
// OWN_R | renderer holds the port under lock
// OWN_C | collision detector holds the port under lock
module tilemap_port_arbiter #(
  parameter int MEM_LAT  = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  tilemap_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_R = 2'd1,
    OWN_C = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               last_c, last_c_nxt;
  logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
  logic               gnt_r, gnt_c;
  logic               timeout;
  logic [MEM_LAT-1:0] pipe_v;
  logic [MEM_LAT-1:0] pipe_id;

  assign timeout = (lock_cnt == CNT_W'(MAX_LOCK));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      last_c   <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_c   <= last_c_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_c_nxt   = last_c;
    lock_cnt_nxt = lock_cnt;
    case (state)
      IDLE: begin
        if (gnt_r) begin
          last_c_nxt = 1'b0;
          if (bus.r_lock) begin
            state_nxt    = OWN_R;
            lock_cnt_nxt = CNT_W'(1);
          end
        end else if (gnt_c) begin
          last_c_nxt = 1'b1;
          if (bus.c_lock) begin
            state_nxt    = OWN_C;
            lock_cnt_nxt = CNT_W'(1);
          end
        end
      end
      // Dropping lock releases the port whether or not this cycle carried a grant.
      OWN_R: begin
        if (timeout || !bus.r_lock) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
      end
      OWN_C: begin
        if (timeout || !bus.c_lock) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  // On timeout the owner yields a dead cycle only if the other side is waiting.
  always_comb begin
    gnt_r = 1'b0;
    gnt_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.r_req && (!bus.c_req || last_c)) gnt_r = 1'b1;
        else if (bus.c_req)                      gnt_c = 1'b1;
      end
      OWN_R:   gnt_r = bus.r_req && !(timeout && bus.c_req);
      OWN_C:   gnt_c = bus.c_req && !(timeout && bus.r_req);
      default: ;
    endcase
    if (!resetn) begin
      gnt_r = 1'b0;
      gnt_c = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      pipe_v[0]  <= gnt_r | gnt_c;
      pipe_id[0] <= gnt_c;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign bus.r_gnt       = gnt_r;
  assign bus.c_gnt       = gnt_c;
  assign bus.mem_address = gnt_r ? bus.r_addr : (gnt_c ? bus.c_addr : '0);
  assign bus.busy        = (state != IDLE);
  assign bus.r_rvalid    = pipe_v[MEM_LAT-1] & ~pipe_id[MEM_LAT-1];
  assign bus.c_rvalid    = pipe_v[MEM_LAT-1] &  pipe_id[MEM_LAT-1];
  assign bus.r_rdata     = bus.mem_data;
  assign bus.c_rdata     = bus.mem_data;
endmodule

// File: tb/tb_tilemap_port_arbiter.sv
// Bench for tilemap_port_arbiter: two instances (MEM_LAT 1 and 3) on shared stimulus,
// checked every cycle against an ownership/round-robin model plus directed literal cases.
module tb_tilemap_port_arbiter;
  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 4;
  localparam int MAX_LOCK = 8;

  logic              clock  = 1'b0;
  logic              resetn = 1'b0;
  logic              r_req = 1'b0, r_lock = 1'b0, c_req = 1'b0, c_lock = 1'b0;
  logic [ADDR_W-1:0] r_addr = '0, c_addr = '0;
  logic [DATA_W-1:0] mem_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  tilemap_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
  tilemap_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

  assign bus1.r_req = r_req;  assign bus3.r_req = r_req;
  assign bus1.r_lock = r_lock; assign bus3.r_lock = r_lock;
  assign bus1.r_addr = r_addr; assign bus3.r_addr = r_addr;
  assign bus1.c_req = c_req;  assign bus3.c_req = c_req;
  assign bus1.c_lock = c_lock; assign bus3.c_lock = c_lock;
  assign bus1.c_addr = c_addr; assign bus3.c_addr = c_addr;
  assign bus1.mem_data = mem_data; assign bus3.mem_data = mem_data;

  tilemap_port_arbiter #(.MEM_LAT(1), .MAX_LOCK(MAX_LOCK)) dut1 (
    .clock(clock), .resetn(resetn), .bus(bus1.slave));
  tilemap_port_arbiter #(.MEM_LAT(3), .MAX_LOCK(MAX_LOCK)) dut3 (
    .clock(clock), .resetn(resetn), .bus(bus3.slave));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: owner 0=none,1=R,2=C; held = cycles owned so far; last = last winner.
  int m_owner = 0;
  int m_held  = 0;
  int m_last  = 2;
  int hist[4] = '{0, 0, 0, 0};

  always @(negedge clock) begin : compare
    int g;
    int other_wants, owner_wants, owner_lock;
    bit to;
    logic [ADDR_W-1:0] ea;
    g  = 0;
    ea = '0;
    if (!resetn) begin
      m_owner = 0; m_held = 0; m_last = 2;
      hist = '{0, 0, 0, 0};
    end else if (m_owner == 0) begin
      if (r_req && c_req) g = (m_last == 1) ? 2 : 1;
      else if (r_req)     g = 1;
      else if (c_req)     g = 2;
    end else begin
      owner_wants = (m_owner == 1) ? int'(r_req) : int'(c_req);
      other_wants = (m_owner == 1) ? int'(c_req) : int'(r_req);
      to = (m_held >= MAX_LOCK);
      if (!(to && other_wants != 0) && owner_wants != 0) g = m_owner;
    end
    if (g == 1) ea = r_addr;
    if (g == 2) ea = c_addr;

    check("gnt_r_lat1", bus1.r_gnt, (g == 1));
    check("gnt_c_lat1", bus1.c_gnt, (g == 2));
    check("gnt_r_lat3", bus3.r_gnt, (g == 1));
    check("gnt_c_lat3", bus3.c_gnt, (g == 2));
    check("addr_lat1", bus1.mem_address, ea);
    check("addr_lat3", bus3.mem_address, ea);
    check("busy", bus1.busy, (resetn && m_owner != 0));
    check("rvalid_r_lat1", bus1.r_rvalid, (hist[0] == 1));
    check("rvalid_c_lat1", bus1.c_rvalid, (hist[0] == 2));
    check("rvalid_r_lat3", bus3.r_rvalid, (hist[2] == 1));
    check("rvalid_c_lat3", bus3.c_rvalid, (hist[2] == 2));
    check("rdata_r", bus1.r_rdata, mem_data);
    check("rdata_c", bus3.c_rdata, mem_data);

    if (resetn) begin
      if (m_owner == 0) begin
        if (g != 0) begin
          m_last = g;
          if ((g == 1 && r_lock) || (g == 2 && c_lock)) begin
            m_owner = g;
            m_held  = 1;
          end
        end
      end else begin
        owner_lock = (m_owner == 1) ? int'(r_lock) : int'(c_lock);
        if (m_held >= MAX_LOCK || owner_lock == 0) begin
          m_owner = 0;
          m_held  = 0;
        end else begin
          m_held++;
        end
      end
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = g;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    tick();
    resetn = 1'b0;
    r_req = 0; r_lock = 0; c_req = 0; c_lock = 0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    bit r_mode, c_mode;
    r_mode = 0;
    c_mode = 0;

    // Reset holds grants low even with a request pending; then single renderer read.
    r_req = 1; r_addr = 15'h0010;
    repeat (2) begin
      @(negedge clock);
      check("rst_r_gnt", bus1.r_gnt, 0);
      check("rst_addr", bus1.mem_address, 0);
    end
    tick();
    resetn = 1'b1;
    @(negedge clock);
    check("single_r_gnt", bus1.r_gnt, 1);
    check("single_addr", bus1.mem_address, 32'h10);
    tick();
    r_req = 0;
    @(negedge clock);
    check("single_r_rvalid", bus1.r_rvalid, 1);

    // Both requesting, no locks: R,C,R,C,R,C; MEM_LAT=3 returns at T+3..T+5.
    do_reset();
    r_req = 1; c_req = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("alt_r_gnt", bus1.r_gnt, (i % 2 == 0));
      check("alt_c_gnt", bus1.c_gnt, (i % 2 == 1));
      if (i >= 1) check("alt_r_rv1", bus1.r_rvalid, (i % 2 == 1));
      if (i >= 3) begin
        check("alt_r_rv3", bus3.r_rvalid, (i % 2 == 1));
        check("alt_c_rv3", bus3.c_rvalid, (i % 2 == 0));
      end
      tick();
    end
    r_req = 0; c_req = 0;

    // Collision 4-read locked burst against a waiting renderer.
    do_reset();
    r_req = 1;
    @(negedge clock);
    check("burst_pre_r", bus1.r_gnt, 1);
    tick();
    c_req = 1;
    for (int k = 0; k < 4; k++) begin
      c_lock = (k < 3);
      @(negedge clock);
      check("burst_c_gnt", bus1.c_gnt, 1);
      check("burst_r_held", bus1.r_gnt, 0);
      tick();
    end
    c_req = 0; c_lock = 0;
    @(negedge clock);
    check("burst_then_r", bus1.r_gnt, 1);
    tick();
    r_req = 0;

    // Lock held forever: 8 C grants, one dead cycle, then R.
    do_reset();
    c_req = 1; c_lock = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("to_c_gnt", bus1.c_gnt, (k < 8));
      check("to_r_gnt", bus1.r_gnt, (k == 9));
      check("to_busy", bus1.busy, (k >= 1 && k <= 8));
      tick();
      r_req = 1;
    end
    r_req = 0; c_req = 0; c_lock = 0;

    // Reset right after a grant drops the in-flight return.
    do_reset();
    r_req = 1; r_addr = 15'h1234;
    @(negedge clock);
    check("mid_rst_gnt", bus3.r_gnt, 1);
    tick();
    resetn = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      check("mid_rst_rv1", bus1.r_rvalid, 0);
      check("mid_rst_rv3", bus3.r_rvalid, 0);
      if (k < 2) begin
        check("mid_rst_gnt0", bus1.r_gnt, 0);
        check("mid_rst_busy", bus3.busy, 0);
      end
      tick();
      if (k == 1) begin
        resetn = 1'b1;
        r_req = 0;
      end
    end

    // Randomized traffic with lock bursts and occasional resets.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 19) == 0) r_mode = ~r_mode;
      if ($urandom_range(0, 19) == 0) c_mode = ~c_mode;
      r_req  = ($urandom_range(0, 99) < 60);
      c_req  = ($urandom_range(0, 99) < 60);
      r_lock = r_mode ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
      c_lock = c_mode ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
      r_addr = ADDR_W'($urandom);
      c_addr = ADDR_W'($urandom);
      mem_data = DATA_W'($urandom);
      if (resetn && $urandom_range(0, 399) == 0) resetn = 1'b0;
      else if (!resetn && $urandom_range(0, 2) == 0) resetn = 1'b1;
      tick();
    end
    r_req = 0; c_req = 0; r_lock = 0; c_lock = 0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
